// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS datapath types and constants
//
// Purpose: widths, reset defaults and the fetch->decode bundle used by
// fetch_unit, fetch_skid_buffer and the decode stage.
// Ports: none (package).
package mips_pkg;

  localparam int INSTR_WIDTH = 32;
  localparam int PC_WIDTH = 32;

  // Word index fetched first after reset unless a block overrides it.
  localparam int unsigned DEFAULT_RESET_PC = 0;

  localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0000;

  // One fetched instruction together with the word index it came from.
  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instruction;
    logic [PC_WIDTH-1:0]    pc;
  } fetch_bundle;

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch-to-decode valid/ready handshake
//
// Purpose: carries {instruction, pc} from fetch to decode.
// Signals:
//   out_valid        fetch holds an instruction for decode
//   out_ready        decode accepts this cycle
//   out_instruction  fetched instruction
//   out_pc           word index of out_instruction
// Modports: master (fetch side), slave (decode side).
interface fetch_unit_if #(
  parameter int ADDR_WIDTH = 32
);

  logic                             out_valid;
  logic                             out_ready;
  logic [mips_pkg::INSTR_WIDTH-1:0] out_instruction;
  logic [ADDR_WIDTH-1:0]            out_pc;

  modport master (
    output out_valid,
    output out_instruction,
    output out_pc,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_instruction,
    input  out_pc,
    output out_ready
  );

endinterface

// File: rtl/fetch_skid_buffer.sv
// rtl/fetch_skid_buffer.sv - output register plus one-entry skid with flush
//
// Purpose: holds the instruction presented to decode and absorbs the one
// read that is already in flight when decode stalls.
// Ports:
//   clock, reset_n       clock, asynchronous active-low reset
//   flush                discard output and skid entries at this edge
//   in_valid, in_data    returning memory read (never blocked)
//   out_valid, out_ready handshake towards decode
//   out_data             bundle presented to decode
//   skid_valid           skid entry occupied (fetch must not issue)
module fetch_skid_buffer
  import mips_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        flush,
  input  logic        in_valid,
  input  fetch_bundle in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output fetch_bundle out_data,
  output logic        skid_valid
);

  fetch_bundle skid_data;

  // The issuer only launches a read when this buffer can take it, so an
  // incoming entry never meets a full skid; in_valid has no back-pressure.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      out_data   <= '{instruction: NOP_INSTR, pc: '0};
      skid_valid <= 1'b0;
      skid_data  <= '{instruction: NOP_INSTR, pc: '0};
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (out_valid && out_ready) begin
      // Draining: the older skid entry always goes ahead of new data.
      if (skid_valid) begin
        out_data   <= skid_data;
        skid_valid <= 1'b0;
      end else if (in_valid) begin
        out_data <= in_data;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (!out_valid) begin
      if (in_valid) begin
        out_data  <= in_data;
        out_valid <= 1'b1;
      end
    end else if (in_valid) begin
      skid_data  <= in_data;
      skid_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - MIPS instruction fetch: PC, memory address, decode handshake
//
// Purpose: owns the program counter, drives the word address into the
// synchronous instruction memory (data returns one clock later), and hands
// {instruction, pc} to decode. Decode stalls are absorbed by a one-entry
// skid; a redirect squashes everything in flight and fetches the target.
// Optional: FETCH_PERF_COUNT_EN adds perf_fetched / perf_squashed counters.
// Ports:
//   clock, reset_n                     clock, asynchronous active-low reset
//   mem_address                        word index to instruction memory
//   mem_instruction                    read data for the previous address
//   redirect_valid, redirect_target    taken branch/jump and its word index
//   dec (fetch_unit_if.master)         out_valid/out_ready/out_instruction/out_pc
//   perf_fetched, perf_squashed        (FETCH_PERF_COUNT_EN only)
module fetch_unit
  import mips_pkg::*;
#(
  parameter int          ADDR_WIDTH = 32,
  parameter int unsigned MEM_DEPTH  = 64,
  parameter int unsigned RESET_PC   = DEFAULT_RESET_PC
) (
  input  logic                   clock,
  input  logic                   reset_n,
  output logic [ADDR_WIDTH-1:0]  mem_address,
  input  logic [INSTR_WIDTH-1:0] mem_instruction,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_target,
  fetch_unit_if.master           dec
`ifdef FETCH_PERF_COUNT_EN
  ,
  output logic [31:0]            perf_fetched,
  output logic [31:0]            perf_squashed
`endif
);

  // MEM_DEPTH is a power of two, so wrapping is a mask.
  localparam logic [ADDR_WIDTH-1:0] INDEX_MASK  = ADDR_WIDTH'(MEM_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] RESET_INDEX = ADDR_WIDTH'(RESET_PC) & INDEX_MASK;

  logic [ADDR_WIDTH-1:0] pc;
  logic                  pending;
  logic [ADDR_WIDTH-1:0] pending_pc;
  logic                  skid_valid;
  logic                  redirect;
  logic                  stalled;
  logic                  issue;
  logic [ADDR_WIDTH-1:0] fetch_index;
  fetch_bundle           ret_data;
  fetch_bundle           out_data;

  // Redirect has no effect while reset is held, including on mem_address.
  assign redirect = redirect_valid && reset_n;

  // A read returning now into a held output register lands in the skid;
  // issuing another one this cycle would have nowhere to go.
  assign stalled     = pending && dec.out_valid && !dec.out_ready;
  assign issue       = redirect || (!skid_valid && !stalled);
  assign fetch_index = redirect ? (redirect_target & INDEX_MASK) : pc;
  assign mem_address = fetch_index;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc         <= RESET_INDEX;
      pending    <= 1'b0;
      pending_pc <= '0;
    end else begin
      pending <= issue;
      if (issue) begin
        pending_pc <= fetch_index;
        pc         <= (fetch_index + 1'b1) & INDEX_MASK;
      end
    end
  end

  assign ret_data = '{instruction: mem_instruction, pc: PC_WIDTH'(pending_pc)};

  // The read returning during a redirect belongs to the squashed path.
  fetch_skid_buffer u_skid (
    .clock      (clock),
    .reset_n    (reset_n),
    .flush      (redirect),
    .in_valid   (pending && !redirect),
    .in_data    (ret_data),
    .out_valid  (dec.out_valid),
    .out_ready  (dec.out_ready),
    .out_data   (out_data),
    .skid_valid (skid_valid)
  );

  assign dec.out_instruction = out_data.instruction;
  assign dec.out_pc          = ADDR_WIDTH'(out_data.pc);

`ifdef FETCH_PERF_COUNT_EN
  logic [31:0] squash_count;

  assign squash_count = 32'(pending) + 32'(dec.out_valid) + 32'(skid_valid);

  // A handshake in a redirect cycle is still a delivered instruction.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetched  <= '0;
      perf_squashed <= '0;
    end else begin
      if (dec.out_valid && dec.out_ready) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (redirect) begin
        perf_squashed <= perf_squashed + squash_count;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with random stalls and redirects
module tb_fetch_unit;
  import mips_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic [31:0] mem_address;
  logic [31:0] mem_instruction;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;

  fetch_unit_if #(.ADDR_WIDTH(32)) dec ();

`ifdef FETCH_PERF_COUNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_squashed;
`endif

  fetch_unit #(.ADDR_WIDTH(32), .MEM_DEPTH(64), .RESET_PC(0)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .mem_address     (mem_address),
    .mem_instruction (mem_instruction),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .dec             (dec)
`ifdef FETCH_PERF_COUNT_EN
    ,
    .perf_fetched    (perf_fetched),
    .perf_squashed   (perf_squashed)
`endif
  );

  always #5 clock = ~clock;

  // Synchronous instruction memory, word i = 1000_0000 + i.
  logic [31:0] mem [64];
  initial for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
  always @(posedge clock) mem_instruction <= mem[mem_address[5:0]];

  int n_vec = 0;
  int n_err = 0;
  int exp_q[$];
  int nxt = 0;
  int mon_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted instruction must be the next one of the
  // reference stream (sequential mod 64 from the last redirect or reset).
  always @(negedge clock) begin
    if (reset_n === 1'b1 && dec.out_valid === 1'b1 && dec.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_pc", 64'(dec.out_pc), 64'(mon_e));
        chk("sb_instr", 64'(dec.out_instruction), 64'(32'h1000_0000 + mon_e));
      end
    end
  end

  // Advance one clock; inputs of the cycle just ended are still applied,
  // so a redirect there restarts the reference stream at its target.
  task automatic tick();
    @(posedge clock);
    #1;
    if (redirect_valid) begin
      exp_q.delete();
      nxt = int'(redirect_target % 64);
    end
    while (exp_q.size() < 4) begin
      exp_q.push_back(nxt);
      nxt = (nxt + 1) % 64;
    end
  endtask

  task automatic drive(input logic rdy, input logic rv, input int tgt);
    dec.out_ready   = rdy;
    redirect_valid  = rv;
    redirect_target = 32'(tgt);
  endtask

  task automatic release_reset();
    exp_q.delete();
    nxt = 0;
    reset_n = 1'b1;
  endtask

  int cnt;
  bit found;
  logic [4:0] pat;

  initial begin
    // Reset, with a redirect that must be ignored.
    drive(1, 1, 9);
    #1 reset_n = 1'b0;
    #11;
    chk("rst_valid", 64'(dec.out_valid), 64'd0);
    chk("rst_pc", 64'(dec.out_pc), 64'd0);
    chk("rst_instr", 64'(dec.out_instruction), 64'd0);
    chk("rst_addr", 64'(mem_address), 64'd0);
    drive(1, 0, 0);
    @(posedge clock);
    #3 release_reset();
    tick();
    chk("lat_cycle1_valid", 64'(dec.out_valid), 64'd0);
    tick();
    chk("lat_cycle2_valid", 64'(dec.out_valid), 64'd1);
    chk("lat_cycle2_pc", 64'(dec.out_pc), 64'd0);

    // Ten accepted fetches, stall with skid full, then two back-to-back redirects.
    cnt = 1;
    for (int k = 0; k < 40 && cnt < 10; k++) begin
      tick();
      if (dec.out_valid) cnt++;
    end
    tick();
    drive(0, 0, 0);
    chk("stream_pc10", 64'(dec.out_pc), 64'd10);
    repeat (3) begin
      tick();
      chk("stall_hold_pc", 64'(dec.out_pc), 64'd10);
      chk("stall_addr", 64'(mem_address), 64'd12);
    end
    tick();
    drive(0, 1, 20);
    tick();
    drive(0, 1, 30);
    chk("dbl_redir_n1_valid", 64'(dec.out_valid), 64'd0);
    tick();
    drive(1, 0, 0);
    chk("dbl_redir_n2_valid", 64'(dec.out_valid), 64'd0);
`ifdef FETCH_PERF_COUNT_EN
    chk("perf_fetched", 64'(perf_fetched), 64'd10);
    chk("perf_squashed", 64'(perf_squashed), 64'd3);
`endif
    tick();
    chk("dbl_redir_n3_valid", 64'(dec.out_valid), 64'd1);
    chk("dbl_redir_n3_pc", 64'(dec.out_pc), 64'd30);

    // Asynchronous reset between edges while streaming.
    repeat (3) tick();
    #3 reset_n = 1'b0;
    #1;
    chk("arst_valid", 64'(dec.out_valid), 64'd0);
    chk("arst_addr", 64'(mem_address), 64'd0);
    @(posedge clock);
    @(posedge clock);
    #3 release_reset();
    tick();
    chk("arst_n1_valid", 64'(dec.out_valid), 64'd0);
    tick();
    chk("arst_n2_valid", 64'(dec.out_valid), 64'd1);
    chk("arst_n2_pc", 64'(dec.out_pc), 64'd0);

    // Stall for 5 cycles with pc 3 on the output.
    found = 0;
    for (int k = 0; k < 20; k++) begin
      if (dec.out_valid && dec.out_pc == 3) begin
        found = 1;
        break;
      end
      tick();
    end
    drive(0, 0, 0);
    chk("find_pc3", 64'(found), 64'd1);
    repeat (4) begin
      tick();
      chk("stall3_pc", 64'(dec.out_pc), 64'd3);
      chk("stall3_valid", 64'(dec.out_valid), 64'd1);
      chk("stall3_addr", 64'(mem_address), 64'd5);
    end
    tick();
    drive(1, 0, 0);
    pat[4] = dec.out_valid;
    for (int i = 3; i >= 0; i--) begin
      tick();
      pat[i] = dec.out_valid;
    end
    chk("release_bubble", 64'(pat), 64'(5'b11011));

    // Redirect to 20 while output and skid are held.
    repeat (3) tick();
    drive(0, 0, 0);
    repeat (3) tick();
    tick();
    drive(0, 1, 20);
    #1 chk("redir20_addr", 64'(mem_address), 64'd20);
    tick();
    drive(1, 0, 0);
    chk("redir20_n1_valid", 64'(dec.out_valid), 64'd0);
    tick();
    chk("redir20_n2_valid", 64'(dec.out_valid), 64'd1);
    chk("redir20_n2_pc", 64'(dec.out_pc), 64'd20);

    // Wrap across 63 and an out-of-range target.
    tick();
    drive(1, 1, 60);
    tick();
    drive(1, 0, 0);
    repeat (7) tick();
    tick();
    drive(1, 1, 70);
    #1 chk("redir70_addr", 64'(mem_address), 64'd6);
    tick();
    drive(1, 0, 0);
    tick();
    chk("redir70_valid", 64'(dec.out_valid), 64'd1);
    chk("redir70_pc", 64'(dec.out_pc), 64'd6);
    chk("redir70_instr", 64'(dec.out_instruction), 64'h1000_0006);

    // Random stalls and redirects, checked by the scoreboard.
    repeat (500) begin
      tick();
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, int'($urandom_range(0, 255)));
    end
    tick();
    drive(1, 0, 0);
    repeat (8) tick();
    chk("final_stream_valid", 64'(dec.out_valid), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
